// File: rtl/sram_axi_bridge.sv
// Single-outstanding SRAM-like request port to AXI3 master bridge.
// Issues one single-beat read or write at a time and holds AXI valids until handshake.
module sram_axi_bridge #(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic        aclk_0,
    input  logic        areset_0,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  M_AXI_arid,
    output logic [31:0] M_AXI_araddr,
    output logic [7:0]  M_AXI_arlen,
    output logic [2:0]  M_AXI_arsize,
    output logic [1:0]  M_AXI_arburst,
    output logic [1:0]  M_AXI_arlock,
    output logic [3:0]  M_AXI_arcache,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,
    input  logic [3:0]  M_AXI_rid,
    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rlast,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready,
    output logic [3:0]  M_AXI_awid,
    output logic [31:0] M_AXI_awaddr,
    output logic [7:0]  M_AXI_awlen,
    output logic [2:0]  M_AXI_awsize,
    output logic [1:0]  M_AXI_awburst,
    output logic [1:0]  M_AXI_awlock,
    output logic [3:0]  M_AXI_awcache,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [3:0]  M_AXI_wid,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wlast,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [3:0]  M_AXI_bid,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] buf_addr, buf_wdata;
    logic [1:0]  buf_size;
    logic [3:0]  buf_strb, strb_nxt;
    logic        aw_done, w_done;
    logic        accept;
    logic [2:0]  axsize;

    // Single-beat transfers only: responses carry no information we need beyond data/resp.
    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_rid, M_AXI_rlast, M_AXI_bid};

    assign addr_ok = (state == IDLE) && !areset_0;
    assign accept  = req && addr_ok;

    always_comb begin
        case (size)
            2'd0:    strb_nxt = 4'b0001 << addr[1:0];
            2'd1:    strb_nxt = 4'b0011 << {addr[1], 1'b0};
            default: strb_nxt = 4'b1111;
        endcase
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;
        M_AXI_awvalid = 1'b0;
        M_AXI_wvalid  = 1'b0;
        M_AXI_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = wr ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                M_AXI_arvalid = 1'b1;
                if (M_AXI_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_rready = 1'b1;
                if (M_AXI_rvalid) state_nxt = IDLE;
            end
            WR_REQ: begin
                M_AXI_awvalid = !aw_done;
                M_AXI_wvalid  = !w_done;
                // Address and data channels may complete in either order or together.
                if ((aw_done || M_AXI_awready) && (w_done || M_AXI_wready))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_bready = 1'b1;
                if (M_AXI_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) begin
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_size  <= '0;
            buf_strb  <= '0;
        end else if (accept) begin
            buf_addr  <= addr;
            buf_wdata <= wdata;
            buf_size  <= size;
            buf_strb  <= strb_nxt;
        end
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept && wr) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (M_AXI_awvalid && M_AXI_awready) aw_done <= 1'b1;
            if (M_AXI_wvalid && M_AXI_wready)   w_done  <= 1'b1;
        end
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) begin
            data_ok <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= 1'b0;
            err     <= 1'b0;
            if (state == RD_DATA && M_AXI_rvalid) begin
                data_ok <= 1'b1;
                err     <= (M_AXI_rresp != 2'b00);
                rdata   <= M_AXI_rdata;
            end else if (state == WR_RESP && M_AXI_bvalid) begin
                data_ok <= 1'b1;
                err     <= (M_AXI_bresp != 2'b00);
            end
        end
    end

    assign axsize = {1'b0, (buf_size == 2'd3) ? 2'd2 : buf_size};

    assign M_AXI_arid    = ID;
    assign M_AXI_araddr  = buf_addr;
    assign M_AXI_arlen   = 8'd0;
    assign M_AXI_arsize  = axsize;
    assign M_AXI_arburst = 2'b01;
    assign M_AXI_arlock  = 2'b00;
    assign M_AXI_arcache = 4'b0000;
    assign M_AXI_arprot  = 3'b000;

    assign M_AXI_awid    = ID;
    assign M_AXI_awaddr  = buf_addr;
    assign M_AXI_awlen   = 8'd0;
    assign M_AXI_awsize  = axsize;
    assign M_AXI_awburst = 2'b01;
    assign M_AXI_awlock  = 2'b00;
    assign M_AXI_awcache = 4'b0000;
    assign M_AXI_awprot  = 3'b000;

    assign M_AXI_wid     = ID;
    assign M_AXI_wdata   = buf_wdata;
    assign M_AXI_wstrb   = buf_strb;
    assign M_AXI_wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed cycle-by-cycle bench for sram_axi_bridge; the bench plays the AXI slave by hand.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdat_o, rdat_i;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    sram_axi_bridge #(.ID(4'd0)) dut (
        .aclk_0(clk), .areset_0(rst), .req(req), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err),
        .M_AXI_arid(arid), .M_AXI_araddr(araddr), .M_AXI_arlen(arlen),
        .M_AXI_arsize(arsize), .M_AXI_arburst(arburst), .M_AXI_arlock(arlock),
        .M_AXI_arcache(arcache), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid),
        .M_AXI_arready(arready),
        .M_AXI_rid(rid), .M_AXI_rdata(rdat_i), .M_AXI_rresp(rresp),
        .M_AXI_rlast(rlast), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready),
        .M_AXI_awid(awid), .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen),
        .M_AXI_awsize(awsize), .M_AXI_awburst(awburst), .M_AXI_awlock(awlock),
        .M_AXI_awcache(awcache), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid),
        .M_AXI_awready(awready),
        .M_AXI_wid(wid), .M_AXI_wdata(wdat_o), .M_AXI_wstrb(wstrb),
        .M_AXI_wlast(wlast), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid),
        .M_AXI_bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a further unit.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        arready = 1'b0; rid = '0; rdat_i = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        // Reset state
        repeat (3) step();
        #1;
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
        chk("rst_readys", {rready, bready}, 0);
        chk("rst_data_ok_err", {data_ok, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_araddr", araddr, 0);
        rst = 1'b0;
        #1;
        chk("rel_addr_ok", addr_ok, 1);

        // Zero-wait word read
        step();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1FC0_0000;
        #1;
        chk("rd0_accept", addr_ok, 1);
        step();
        req = 1'b0; arready = 1'b1;
        #1;
        chk("rd0_arvalid", arvalid, 1);
        chk("rd0_araddr", araddr, 32'h1FC0_0000);
        chk("rd0_arsize", arsize, 2);
        chk("rd0_arlen", arlen, 0);
        chk("rd0_arburst", arburst, 1);
        chk("rd0_addr_ok_busy", addr_ok, 0);
        step();
        arready = 1'b0; rvalid = 1'b1; rdat_i = 32'hDEAD_BEEF; rresp = 2'b00;
        #1;
        chk("rd0_rready", rready, 1);
        chk("rd0_arvalid_drop", arvalid, 0);
        chk("rd0_no_early_ok", data_ok, 0);
        step();
        rvalid = 1'b0; rdat_i = 32'h0;
        #1;
        chk("rd0_data_ok", data_ok, 1);
        chk("rd0_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd0_err", err, 0);
        chk("rd0_rready_off", rready, 0);

        // Byte write to lane 3
        req = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h8000_0003; wdata = 32'hAB00_0000;
        step();
        chk("rd0_ok_pulse", data_ok, 0);
        chk("rd0_rdata_hold", rdata, 32'hDEAD_BEEF);
        req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        chk("wb_valids", {awvalid, wvalid}, 2'b11);
        chk("wb_wstrb", wstrb, 4'b1000);
        chk("wb_awsize", awsize, 0);
        chk("wb_wlast", wlast, 1);
        chk("wb_awaddr", awaddr, 32'h8000_0003);
        chk("wb_wdata", wdat_o, 32'hAB00_0000);
        step();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("wb_bready", bready, 1);
        chk("wb_valids_drop", {awvalid, wvalid}, 0);
        step();
        bvalid = 1'b0;
        #1;
        chk("wb_data_ok", {data_ok, err}, 2'b10);

        // Word write, wready at once, awready held off 4 cycles
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h1000_0004; wdata = 32'h1234_5678;
        step();
        req = 1'b0; wready = 1'b1;
        #1;
        chk("wd_c1_valids", {awvalid, wvalid}, 2'b11);
        chk("wd_wstrb", wstrb, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            wready = 1'b0;
            awready = (i == 3);
            #1;
            chk("wd_wvalid_dropped", wvalid, 0);
            chk("wd_awvalid_held", awvalid, 1);
            chk("wd_awaddr_stable", awaddr, 32'h1000_0004);
            chk("wd_no_bready", bready, 0);
        end
        step();
        awready = 1'b0; bvalid = 1'b1;
        #1;
        chk("wd_bready", bready, 1);
        chk("wd_awvalid_drop", awvalid, 0);
        step();
        bvalid = 1'b0;
        #1;
        chk("wd_data_ok", data_ok, 1);

        // Halfword write to upper half, SLVERR response
        req = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h4000_0002; wdata = 32'hBEEF_0000;
        step();
        req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        chk("wh_wstrb", wstrb, 4'b1100);
        chk("wh_awsize", awsize, 1);
        step();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        #1;
        chk("wh_bready", bready, 1);
        step();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        chk("wh_ok_err", {data_ok, err}, 2'b11);

        // Halfword read, rvalid delayed 5 cycles with SLVERR
        req = 1'b1; wr = 1'b0; size = 2'd1; addr = 32'h2000_0008;
        step();
        req = 1'b0; arready = 1'b1;
        #1;
        chk("rs_arsize", arsize, 1);
        chk("rs_addr_ok_c1", addr_ok, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            arready = 1'b0;
            #1;
            chk("rs_wait_rready", rready, 1);
            chk("rs_wait_addr_ok", addr_ok, 0);
            chk("rs_wait_no_ok", data_ok, 0);
        end
        step();
        rvalid = 1'b1; rdat_i = 32'hCAFE_F00D; rresp = 2'b10;
        #1;
        chk("rs_rvalid_addr_ok", addr_ok, 0);
        step();
        rvalid = 1'b0; rdat_i = 32'h0; rresp = 2'b00;
        #1;
        chk("rs_ok_err", {data_ok, err}, 2'b11);
        chk("rs_rdata", rdata, 32'hCAFE_F00D);
        step();
        chk("rs_ok_err_once", {data_ok, err}, 0);

        // Back-to-back reads with req held and a zero-wait slave
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_1000;
        arready = 1'b1; rvalid = 1'b1; rdat_i = 32'h55AA_55AA;
        #1;
        chk("bb_accept0", addr_ok, 1);
        step();
        #1;
        chk("bb_araddr0", araddr, 32'h0000_1000);
        step();
        #1;
        chk("bb_rready0", rready, 1);
        step();
        addr = 32'h0000_2000; size = 2'd3;
        #1;
        chk("bb_ok0", data_ok, 1);
        chk("bb_accept1", addr_ok, 1);
        step();
        #1;
        chk("bb_arvalid1", arvalid, 1);
        chk("bb_araddr1", araddr, 32'h0000_2000);
        chk("bb_arsize_sz3", arsize, 2);
        step();
        req = 1'b0;
        #1;
        chk("bb_rready1", rready, 1);
        step();
        arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("bb_ok1", data_ok, 1);
        chk("bb_rdata1", rdata, 32'h55AA_55AA);

        // Reset while in RD_DATA, then a clean read
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h3000_0000;
        step();
        req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rst = 1'b1;
        #1;
        chk("rr_in_rd_data", rready, 1);
        step();
        rst = 1'b0;
        #1;
        chk("rr_rready_off", rready, 0);
        chk("rr_data_ok_off", data_ok, 0);
        chk("rr_idle", addr_ok, 1);
        chk("rr_rdata_cleared", rdata, 0);
        req = 1'b1; addr = 32'h3000_0010;
        step();
        req = 1'b0; arready = 1'b1;
        #1;
        chk("rr_araddr", araddr, 32'h3000_0010);
        step();
        arready = 1'b0; rvalid = 1'b1; rdat_i = 32'h0BAD_C0DE;
        step();
        rvalid = 1'b0;
        #1;
        chk("rr_ok", {data_ok, err}, 2'b10);
        chk("rr_rdata", rdata, 32'h0BAD_C0DE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Single-outstanding bridge that turns a CPU-side SRAM-like request port (one per instruction or data cache path) into an AXI3 master. Each instance drives one slave interface, S00 or S01, of the 2x1 AXI interconnect. It issues single-beat reads and writes only, one transaction at a time. It holds AXI valid signals stable until the handshake completes, so it never aborts a request while the interconnect is serving it.

## Interface
- ID, default 4'd0, constant driven on arid/awid/wid.
- aclk_0  in  1  clock; all logic on the rising edge.
- areset_0  in  1  reset, synchronous and active-high.
- req  in  1  request strobe from the CPU.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as word.
- addr  in  32  byte address; passed to AXI unchanged.
- wdata  in  32  write data, already lane-aligned by the CPU.
- addr_ok  out  1  request accepted this cycle (req & addr_ok).
- data_ok  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid while data_ok=1.
- err  out  1  high with data_ok when the response code is nonzero.
- M_AXI_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  4/32/8/3/2/2/4/3/1; M_AXI_arready  in  1.
- M_AXI_r{id,data,resp,last,valid}  in  4/32/2/1/1; M_AXI_rready  out  1.
- M_AXI_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out  4/32/8/3/2/2/4/3/1; M_AXI_awready  in  1.
- M_AXI_w{id,data,strb,last,valid}  out  4/32/4/1/1; M_AXI_wready  in  1.
- M_AXI_b{id,resp,valid}  in  4/2/1; M_AXI_bready  out  1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- addr_ok = (state==IDLE) & !areset_0.
- IDLE, req=1 (accept):
  - Register addr, size, wdata and wstrb into the request buffer.
  - wr=0: go to RD_ADDR.
  - wr=1: go to WR_REQ, and clear aw_done and w_done.
- wstrb rules:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1],1'b0}.
  - size 2/3: 4'b1111.
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Register rdata=rdata_in, err=(rresp!=0), data_ok=1.
  - Go to IDLE.
  - rlast is ignored; len is always 0.
- WR_REQ:
  - awvalid = !aw_done and wvalid = !w_done.
  - aw_done and w_done are set on their respective handshakes.
  - Go to WR_RESP in the cycle where both are done, or complete together.
- WR_RESP: bready=1. On bvalid: err=(bresp!=0), data_ok=1, go to IDLE.
- Constant AXI fields:
  - len = 0, burst = 2'b01, lock = 0, cache = 4'b0000, prot = 3'b000.
  - wlast = 1.
  - ar/awsize = {1'b0, size==3 ? 2 : size}.
- All AXI address and data outputs come from the request buffer. They do not change while valid is high.
- data_ok is a registered pulse that lasts exactly one cycle. rdata holds its value until the next read completes.
- A new req may be accepted in the same cycle data_ok is high, since the state is already IDLE.
- Reset mid-transaction:
  - State goes to IDLE and all valid/ready/data_ok/err outputs go to 0 the next cycle.
  - The partially issued AXI transaction is abandoned. The system resets the interconnect and slave together.

## Timing
- Reset values:
  - Outputs: addr_ok=0 while reset is asserted, all valid/ready=0, data_ok=0, err=0, rdata=0.
  - Internal: aw_done=0, w_done=0, request buffer=0.
- Read with no wait states:
  - Accept at cycle 0.
  - arvalid at cycle 1, with arready at cycle 1.
  - rready at cycle 2, with rvalid at cycle 2.
  - data_ok at cycle 3.
  - Minimum latency: 3 cycles from accept to data_ok.
- Write with no wait states:
  - Accept at cycle 0.
  - awvalid and wvalid at cycle 1, both handshake.
  - bready at cycle 2, with bvalid.
  - data_ok at cycle 3.
- Each AXI wait state adds exactly one cycle.
- Throughput: with a zero-wait slave, one transaction every 3 cycles.
- No combinational path from any AXI input to any AXI output. Ready signals depend only on state.

## Test plan
- Reset, then read of 0x1FC0_0000 with a zero-wait slave returning 0xDEAD_BEEF:
  - araddr=0x1FC0_0000, arsize=2, arlen=0 at cycle 1.
  - data_ok, rdata=0xDEAD_BEEF at cycle 3, err=0.
- Byte write, addr 0x8000_0003, wdata 0xAB00_0000:
  - wstrb=4'b1000, awsize=0, wlast=1.
  - data_ok 1 cycle after bvalid&bready.
- Write where awready is delayed 4 cycles and wready arrives at cycle 1:
  - wvalid drops after cycle 1; awvalid is held with stable awaddr until its handshake.
  - bready is asserted only after both handshakes.
- Read where rvalid is delayed 5 cycles and rresp=2'b10:
  - data_ok and err high together for exactly one cycle.
  - addr_ok=0 throughout the transaction.
- Back-to-back requests with req held high:
  - The second request is accepted in the data_ok cycle of the first.
  - No gap beyond the 3-cycle turnaround.
- areset_0 asserted while in RD_DATA:
  - Next cycle: state IDLE, rready=0, data_ok=0.
  - After release, a new read completes normally.
